// File: rtl/lcd1602_frame_feeder.sv
// lcd1602_frame_feeder
// Holds a 2x16 character frame buffer and streams the HD44780 init sequence
// followed by full-frame refreshes as rs/data bytes on a valid/ready handshake.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_INIT     | emit FUNC_SET, DISP_CTRL, ENTRY_MODE, clear (8'h01)
// S_CLR_WAIT | silent for CLEAR_WAIT cycles while the display clears
// S_IDLE     | nothing to send; start a frame when dirty or refresh
// S_L1_ADDR  | emit line-1 address command 8'h80
// S_L1_CHR   | emit buffer entries 0..15 as character data
// S_L2_ADDR  | emit line-2 address command 8'hC0
// S_L2_CHR   | emit buffer entries 16..31 as character data
module lcd1602_frame_feeder #(
   parameter logic [7:0]  FUNC_SET   = 8'h38,
   parameter logic [7:0]  DISP_CTRL  = 8'h0C,
   parameter logic [7:0]  ENTRY_MODE = 8'h06,
   parameter logic [15:0] CLEAR_WAIT = 16'd2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       refresh,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_rs,
   output logic [7:0] out_data,
   output logic       init_done,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_INIT, S_CLR_WAIT, S_IDLE, S_L1_ADDR, S_L1_CHR, S_L2_ADDR, S_L2_CHR
   } state_t;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_LINE1 = 8'h80;
   localparam logic [7:0] CMD_LINE2 = 8'hC0;
   localparam logic [7:0] CHR_SPACE = 8'h20;

   state_t      state_q, state_d;
   logic [1:0]  step_q, step_d;
   logic [3:0]  col_q, col_d;
   logic [15:0] wait_q, wait_d;
   logic        dirty_q, dirty_d;
   logic        init_done_q, init_done_d;
   logic        busy_q, busy_d;
   logic        out_valid_q, out_valid_d;
   logic        out_rs_q, out_rs_d;
   logic [7:0]  out_data_q, out_data_d;
   logic [7:0]  buf_q [32];
   logic [7:0]  buf_d [32];

   // Next-state, output-byte loading, dirty tracking and buffer writes.
   // A byte is loaded only while out_valid is low and retired only while it
   // is high, which yields the one idle cycle between consecutive bytes.
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      col_d       = col_q;
      wait_d      = wait_q;
      dirty_d     = dirty_q;
      init_done_d = init_done_q;
      out_valid_d = out_valid_q;
      out_rs_d    = out_rs_q;
      out_data_d  = out_data_q;
      buf_d       = buf_q;

      case (state_q)
         S_INIT: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_rs_d    = 1'b0;
               case (step_q)
                  2'd0:    out_data_d = FUNC_SET;
                  2'd1:    out_data_d = DISP_CTRL;
                  2'd2:    out_data_d = ENTRY_MODE;
                  default: out_data_d = CMD_CLEAR;
               endcase
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               if (step_q == 2'd3) begin
                  state_d = S_CLR_WAIT;
                  wait_d  = CLEAR_WAIT;
               end else begin
                  step_d = step_q + 2'd1;
               end
            end
         end
         S_CLR_WAIT: begin
            if (wait_q <= 16'd1) begin
               wait_d      = 16'd0;
               init_done_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               wait_d = wait_q - 16'd1;
            end
         end
         S_IDLE: begin
            if (dirty_q || refresh) begin
               dirty_d = 1'b0;
               state_d = S_L1_ADDR;
            end
         end
         S_L1_ADDR, S_L2_ADDR: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_rs_d    = 1'b0;
               out_data_d  = (state_q == S_L1_ADDR) ? CMD_LINE1 : CMD_LINE2;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               col_d       = 4'd0;
               state_d     = (state_q == S_L1_ADDR) ? S_L1_CHR : S_L2_CHR;
            end
         end
         S_L1_CHR, S_L2_CHR: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_rs_d    = 1'b1;
               out_data_d  = buf_q[{(state_q == S_L2_CHR), col_q}];
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               if (col_q == 4'd15) begin
                  state_d = (state_q == S_L1_CHR) ? S_L2_ADDR : S_IDLE;
               end else begin
                  col_d = col_q + 4'd1;
               end
            end
         end
         default: state_d = S_INIT;
      endcase

      // Requests arriving while not idle collapse into a single pending frame.
      if (refresh && (state_q != S_IDLE)) begin
         dirty_d = 1'b1;
      end
      if (wr_en) begin
         dirty_d          = 1'b1;
         buf_d[wr_addr]   = wr_data;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset abandons any in-flight byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_INIT;
         step_q      <= 2'd0;
         col_q       <= 4'd0;
         wait_q      <= 16'd0;
         dirty_q     <= 1'b1;
         init_done_q <= 1'b0;
         busy_q      <= 1'b1;
         out_valid_q <= 1'b0;
         out_rs_q    <= 1'b0;
         out_data_q  <= 8'h00;
         for (int i = 0; i < 32; i++) begin
            buf_q[i] <= CHR_SPACE;
         end
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         col_q       <= col_d;
         wait_q      <= wait_d;
         dirty_q     <= dirty_d;
         init_done_q <= init_done_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_rs_q    <= out_rs_d;
         out_data_q  <= out_data_d;
         buf_q       <= buf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_rs    = out_rs_q;
   assign out_data  = out_data_q;
   assign init_done = init_done_q;
   assign busy      = busy_q;

endmodule
